// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: central stall controller for the 5-stage MIPS pipeline.
// Detects register-read hazards that forwarding cannot cover (Tuse/Tnew
// comparison) and holds the front end while the mult/div unit is busy.
// Drives PC enable, IF/ID enable and the ID/EX bubble clear.
// Optional feature macro: HAZARD_STALL_CNT_EN adds a 32-bit stall_cycles
// counter output for CPI measurement.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       d_use_rs,
  input  logic       d_use_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic       d_is_md,
  input  logic [4:0] e_wa,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_wa,
  input  logic [1:0] m_tnew,
  input  logic       e_md_start,
  input  logic       e_md_div,
  output logic       pc_en,
  output logic       fd_en,
  output logic       de_clr,
  output logic       md_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`else
  // stall_cycles port is absent in the default build
`endif
);

  logic [CNT_W-1:0] md_cnt;
  logic             rs_hazard;
  logic             rt_hazard;
  logic             md_stall;
  logic             stall;

  // A producer is "too late" when its result appears after the consumer
  // needs it; Tnew of 3 is always too late, even against a Tuse of 3.
  function automatic logic too_late(input logic [1:0] tnew, input logic [1:0] tuse);
    return (tnew == 2'd3) || (tnew > tuse);
  endfunction

  // Register-read hazards against the E and M stage producers; $zero never hazards.
  always_comb begin
    rs_hazard = d_use_rs && (d_rs != 5'd0) &&
                (((d_rs == e_wa) && too_late(e_tnew, d_tuse_rs)) ||
                 ((d_rs == m_wa) && too_late(m_tnew, d_tuse_rs)));
    rt_hazard = d_use_rt && (d_rt != 5'd0) &&
                (((d_rt == e_wa) && too_late(e_tnew, d_tuse_rt)) ||
                 ((d_rt == m_wa) && too_late(m_tnew, d_tuse_rt)));
  end

  // Mult/div occupancy: a start in E blocks the next md instruction immediately.
  always_comb begin
    md_busy  = (md_cnt != '0);
    md_stall = d_is_md && (md_busy || e_md_start);
    stall    = rs_hazard || rt_hazard || md_stall;
  end

  // Pipeline control outputs; reset forces the front end to run with no bubble.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    pc_en  = !stall;
    fd_en  = !stall;
    de_clr = stall;
    if (reset) begin
      pc_en  = 1'b1;
      fd_en  = 1'b1;
      de_clr = 1'b0;
    end
  end

  // Mult/div busy counter: load on an accepted start, then count down to idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      md_cnt <= '0;
    end else if (e_md_start && (md_cnt == '0)) begin
      md_cnt <= e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  // Stall-cycle counter for CPI measurement; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  // No stall-cycle counter in the default build.
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed test-plan sequences followed by
// randomized stimulus, checked against a behavioural model via a scoreboard.
module tb_hazard_stall_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int CNT_W       = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, e_wa, m_wa;
  logic       d_use_rs, d_use_rt, d_is_md, e_md_start, e_md_div;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       pc_en, fd_en, de_clr, md_busy;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_use_rs   (d_use_rs),
    .d_use_rt   (d_use_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_is_md    (d_is_md),
    .e_wa       (e_wa),
    .e_tnew     (e_tnew),
    .m_wa       (m_wa),
    .m_tnew     (m_tnew),
    .e_md_start (e_md_start),
    .e_md_div   (e_md_div),
    .pc_en      (pc_en),
    .fd_en      (fd_en),
    .de_clr     (de_clr),
    .md_busy    (md_busy)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  typedef struct packed {
    logic       reset;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       is_md;
    logic [4:0] e_wa;
    logic [1:0] e_tnew;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic       md_start;
    logic       md_div;
  } stim_t;

  typedef struct {
    logic        pc_en;
    logic        fd_en;
    logic        de_clr;
    logic        md_busy;
    logic [31:0] sc;
  } exp_t;

  exp_t  sb[$];
  stim_t cur;

  // Model state: the unit is busy in every cycle up to and including last_busy.
  longint      cyc;
  longint      last_busy;
  logic [31:0] m_sc;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic bit late(input int tnew, input int tuse);
    return (tnew == 3) || (tnew > tuse);
  endfunction

  function automatic bit reg_hazard(input int r, input bit u, input int tuse, input stim_t s);
    if (!u || r == 0) return 1'b0;
    return ((r == int'(s.e_wa)) && late(int'(s.e_tnew), tuse)) ||
           ((r == int'(s.m_wa)) && late(int'(s.m_tnew), tuse));
  endfunction

  function automatic bit model_busy();
    return cyc <= last_busy;
  endfunction

  function automatic bit model_stall(input stim_t s);
    return reg_hazard(int'(s.rs), s.use_rs, int'(s.tuse_rs), s) ||
           reg_hazard(int'(s.rt), s.use_rt, int'(s.tuse_rt), s) ||
           (s.is_md && (model_busy() || s.md_start));
  endfunction

  // Advance the model across one rising edge using the inputs held in the cycle before it.
  task automatic model_edge(input stim_t s);
    bit st;
    st = model_stall(s);
    if (s.reset) begin
      last_busy = cyc;
      m_sc      = 32'd0;
    end else begin
      if (s.md_start && !model_busy())
        last_busy = cyc + longint'(s.md_div ? DIV_CYCLES : MULT_CYCLES);
      if (st) m_sc = m_sc + 32'd1;
    end
    cyc++;
  endtask

  task automatic drive(input stim_t s);
    reset      = s.reset;
    d_rs       = s.rs;
    d_rt       = s.rt;
    d_use_rs   = s.use_rs;
    d_use_rt   = s.use_rt;
    d_tuse_rs  = s.tuse_rs;
    d_tuse_rt  = s.tuse_rt;
    d_is_md    = s.is_md;
    e_wa       = s.e_wa;
    e_tnew     = s.e_tnew;
    m_wa       = s.m_wa;
    m_tnew     = s.m_tnew;
    e_md_start = s.md_start;
    e_md_div   = s.md_div;
  endtask

  // Apply one cycle of stimulus and queue the response the model predicts for it.
  task automatic apply(input stim_t s);
    exp_t e;
    bit   st;
    @(posedge clk);
    model_edge(cur);
    #1;
    cur = s;
    drive(s);
    st        = model_stall(s);
    e.md_busy = model_busy();
    e.sc      = m_sc;
    e.pc_en   = s.reset ? 1'b1 : !st;
    e.fd_en   = s.reset ? 1'b1 : !st;
    e.de_clr  = s.reset ? 1'b0 : st;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (vector %0d, t=%0t)", name, act, exp, n_vec, $time);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      check("pc_en",   32'(pc_en),   32'(e.pc_en));
      check("fd_en",   32'(fd_en),   32'(e.fd_en));
      check("de_clr",  32'(de_clr),  32'(e.de_clr));
      check("md_busy", 32'(md_busy), 32'(e.md_busy));
`ifdef HAZARD_STALL_CNT_EN
      check("stall_cycles", stall_cycles, e.sc);
`endif
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t md_op(input bit start, input bit div, input bit is_md);
    stim_t s;
    s          = '0;
    s.md_start = start;
    s.md_div   = div;
    s.is_md    = is_md;
    return s;
  endfunction

  initial begin
    stim_t s;
    cyc       = 0;
    last_busy = -1;
    m_sc      = 32'd0;
    cur       = '0;
    cur.reset = 1'b1;
    drive(cur);
    repeat (2) @(posedge clk);

    // Reset state
    s = idle(); s.reset = 1'b1; s.is_md = 1'b1;
    apply(s);
    apply(idle());

    // Load-use hazard, then the same producer with Tnew = 0
    s = idle(); s.rs = 5'd8; s.use_rs = 1'b1; s.tuse_rs = 2'd0; s.e_wa = 5'd8; s.e_tnew = 2'd2;
    apply(s);
    s.e_tnew = 2'd0;
    apply(s);

    // $zero never hazards; rt against M stage with Tuse 1 then 0
    s = idle(); s.rs = 5'd0; s.use_rs = 1'b1; s.e_wa = 5'd0; s.e_tnew = 2'd2;
    apply(s);
    s = idle(); s.rt = 5'd9; s.use_rt = 1'b1; s.m_wa = 5'd9; s.m_tnew = 2'd1; s.tuse_rt = 2'd1;
    apply(s);
    s.tuse_rt = 2'd0;
    apply(s);
    // Tnew of 3 beats Tuse of 3
    s = idle(); s.rs = 5'd4; s.use_rs = 1'b1; s.tuse_rs = 2'd3; s.e_wa = 5'd4; s.e_tnew = 2'd3;
    apply(s);

    // Mult start with an md instruction held behind it
    apply(md_op(1'b1, 1'b0, 1'b1));
    repeat (7) apply(md_op(1'b0, 1'b0, 1'b1));

    // Div, then a start at md_cnt = 4 that must not reload
    apply(md_op(1'b1, 1'b1, 1'b0));
    repeat (6) apply(idle());
    apply(md_op(1'b1, 1'b0, 1'b0));
    repeat (6) apply(idle());

    // Div, then a start at md_cnt = 1 that is dropped
    apply(md_op(1'b1, 1'b1, 1'b0));
    repeat (9) apply(idle());
    apply(md_op(1'b1, 1'b0, 1'b0));
    repeat (2) apply(idle());

    // Reset mid-op with an md instruction waiting
    apply(md_op(1'b1, 1'b1, 1'b0));
    repeat (4) apply(md_op(1'b0, 1'b0, 1'b1));
    s = md_op(1'b0, 1'b0, 1'b1); s.reset = 1'b1;
    apply(s);
    repeat (2) apply(md_op(1'b0, 1'b0, 1'b1));

    // Non-md instruction while the unit is busy
    apply(md_op(1'b1, 1'b0, 1'b0));
    repeat (2) apply(idle());
    s = idle(); s.rs = 5'd3; s.use_rs = 1'b1; s.e_wa = 5'd5; s.e_tnew = 2'd2;
    apply(s);
    repeat (4) apply(idle());

    // Randomized traffic with small register indices so hazards are common
    for (int i = 0; i < 2000; i++) begin
      s          = '0;
      s.reset    = ($urandom_range(0, 63) == 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.use_rs   = 1'($urandom_range(0, 1));
      s.use_rt   = 1'($urandom_range(0, 1));
      s.tuse_rs  = 2'($urandom_range(0, 3));
      s.tuse_rt  = 2'($urandom_range(0, 3));
      s.is_md    = ($urandom_range(0, 3) == 0);
      s.e_wa     = 5'($urandom_range(0, 3));
      s.e_tnew   = 2'($urandom_range(0, 3));
      s.m_wa     = 5'($urandom_range(0, 3));
      s.m_tnew   = 2'($urandom_range(0, 3));
      s.md_start = ($urandom_range(0, 7) == 0);
      s.md_div   = 1'($urandom_range(0, 1));
      apply(s);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    if (n_cmp < 12) begin
      n_fail++;
      $display("FAIL coverage: %0d comparisons, expected at least 12", n_cmp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central stall controller for the 5-stage MIPS pipeline. It drives the PC register's enable, the IF/ID register enable and the ID/EX bubble-insert clear. It detects register-read hazards that forwarding cannot cover, using Tuse/Tnew comparison. It also owns the HI/LO mult/div busy counter and holds the front end while the multiply/divide unit is occupied.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu after the E-stage start
DIV_CYCLES, 10, busy cycles for div/divu after the E-stage start
CNT_W, 4, md counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
d_rs  in  5  D-stage rs index
d_rt  in  5  D-stage rt index
d_use_rs  in  1  D-stage instr reads rs
d_use_rt  in  1  D-stage instr reads rt
d_tuse_rs  in  2  cycles until rs needed (0 = in D, 1 = in E, 2 = in M)
d_tuse_rt  in  2  same for rt
d_is_md  in  1  D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
e_wa  in  5  E-stage destination register (0 = none)
e_tnew  in  2  E-stage cycles until result is forwardable
m_wa  in  5  M-stage destination register
m_tnew  in  2  M-stage cycles until result is forwardable
e_md_start  in  1  E-stage instr launches mult/div this cycle
e_md_div  in  1  qualifies e_md_start: 1 = div, 0 = mult
pc_en  out  1  PC register load enable
fd_en  out  1  IF/ID register load enable
de_clr  out  1  ID/EX synchronous clear (bubble)
md_busy  out  1  mult/div unit occupied

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, sampled on the rising edge of clk.
- State: md_cnt[CNT_W-1:0]. Reset value 0.
- The stall outputs are combinational from the inputs and md_cnt; md_busy is combinational from md_cnt.
- rs hazard = d_use_rs & (d_rs != 0) & ((d_rs == e_wa & e_tnew > d_tuse_rs) | (d_rs == m_wa & m_tnew > d_tuse_rs)).
- rt hazard: same form using d_rt, d_use_rt, d_tuse_rt.
- A register index of 0 never hazards, even when e_wa or m_wa is 0.
- md_busy = (md_cnt != 0).
- md_stall = d_is_md & (md_busy | e_md_start). A start in E blocks the next md instruction in the same cycle.
- stall = rs_hazard | rt_hazard | md_stall.
- Outputs: pc_en = ~stall; fd_en = ~stall; de_clr = stall.
- While reset is high: pc_en = 1, fd_en = 1, de_clr = 0, regardless of the inputs. md_cnt returns to 0 on that edge, so md_busy reads 0 from the next cycle.
- md counter transitions on each rising edge, evaluated in priority order:
  1. reset: md_cnt <= 0.
  2. e_md_start & md_cnt == 0: md_cnt <= e_md_div ? DIV_CYCLES : MULT_CYCLES.
  3. md_cnt != 0: md_cnt <= md_cnt - 1.
  4. otherwise: hold.
- e_md_start while md_cnt != 0 is ignored (no reload) and the count continues. md_stall normally prevents this case.
- md_cnt == 1 together with e_md_start: no reload; md_cnt goes to 0. The start is dropped.
- Reset mid-count: md_cnt is 0 on the next cycle and no stall is carried over.
- Latency: a mult started at edge N shows md_busy = 1 for exactly MULT_CYCLES cycles (N+1 … N+MULT_CYCLES). A d_is_md instruction proceeds in the first cycle that md_busy = 0.
- Tnew/Tuse are 2-bit unsigned compares. Tnew values of 3 are treated as greater than any Tuse.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: adds output stall_cycles[31:0], reset to 0. It increments on every edge where reset = 0 and stall = 1, and wraps from 32'hFFFFFFFF to 0. It is used for CPI measurement.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Load-use: d_rs = 8, d_use_rs = 1, d_tuse_rs = 0, e_wa = 8, e_tnew = 2 -> pc_en = 0, fd_en = 0, de_clr = 1. With e_tnew = 0 -> pc_en = 1, de_clr = 0.
- $zero: d_rs = 0, e_wa = 0, e_tnew = 2, d_tuse_rs = 0 -> no stall. d_rt = 9, m_wa = 9, m_tnew = 1, d_tuse_rt = 1 -> no stall. Same with d_tuse_rt = 0 -> stall.
- Mult: pulse e_md_start = 1, e_md_div = 0 at edge N, then hold d_is_md = 1:
  - md_busy = 1 on cycles N+1 … N+5.
  - pc_en = 0 from the start cycle through N+5.
  - pc_en = 1 at cycle N+6.
  - With HAZARD_STALL_CNT_EN defined, stall_cycles = 6.
- Div while busy: start div (md_cnt = 10), then pulse e_md_start at md_cnt = 4 -> no reload; md_busy drops after 10 total cycles. Separately, e_md_start at md_cnt = 1 -> md_cnt = 0 next cycle.
- Reset mid-op: start div, assert reset at md_cnt = 6 for 1 cycle with d_is_md = 1 -> during reset pc_en = 1; next cycle md_busy = 0 and pc_en = 1; stall_cycles = 0 if enabled.
- Non-md instruction during busy: md_cnt = 3, d_is_md = 0, no register hazard -> pc_en = 1, de_clr = 0.
